// File: rtl/memaccess_hs_unit.sv
// -----------------------------------------------------------------------------
// memaccess_hs_unit
//
// Handshaked memory-access stage. It takes one request at a time and performs
// a direct read, direct write, indirect read (LDI) or indirect write (STI)
// against a variable-latency data memory. An optional per-phase timeout
// aborts a memory phase that never gets acknowledged.
//
// Handshake semantics (all three interfaces):
//   - req port : a request transfers on a rising edge where req_valid and
//                req_ready are both 1. req_ready is 1 only in IDLE.
//   - dmem port: dmem_req is held with stable dmem_rd/dmem_addr/dmem_din until
//                a rising edge where dmem_ack=1; dmem_ack is ignored whenever
//                dmem_req=0. dmem_dout is valid together with dmem_ack.
//   - rsp port : rsp_valid, mem_out and rsp_err are held stable until a rising
//                edge where rsp_ready=1; the response then retires.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_mode              00 read, 01 write, 10 indirect read, 11 indirect write
//   req_addr, req_wdata   effective/pointer address and store data
//   dmem_req/dmem_ack     memory request strobe / completion
//   dmem_rd               1 = read, 0 = write
//   dmem_addr, dmem_din   memory address and write data
//   dmem_dout             memory read data
//   rsp_valid/rsp_ready   response handshake
//   mem_out               read result (unchanged by writes and timeouts)
//   rsp_err               response carries a timeout abort
//   dbg_state             current FSM state (IDLE=0 IND=1 PTR=2 ACC=3 RESP=4)
//
// Timeout (TIMEOUT>0): each IND/ACC phase may hold dmem_req for at most
// TIMEOUT cycles. An ack in the TIMEOUT-th request cycle still succeeds; with
// no ack by then the phase aborts into RESP with rsp_err=1. TIMEOUT must be
// smaller than 2**CNT_W.
// -----------------------------------------------------------------------------
module memaccess_hs_unit #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              dmem_req,
  output logic              dmem_rd,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_din,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_dout,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] mem_out,
  output logic              rsp_err,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IND  = 3'd1,
    S_PTR  = 3'd2,
    S_ACC  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  localparam logic             TO_EN   = (TIMEOUT > 0);
  // Count value seen in the last permitted request cycle of a phase.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;          // latched mode bit 0: store access
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_rd_q, dmem_rd_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_din_q, dmem_din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   mem_out_q, mem_out_d;

  logic [ADDR_W-1:0]   ptr_w;
  logic                timeout_hit;

  // Pointer is the read word zero-extended or truncated to the address width.
  if (ADDR_W <= DATA_W) begin : g_ptr_trunc
    assign ptr_w = dmem_dout[ADDR_W-1:0];
  end else begin : g_ptr_ext
    assign ptr_w = {{(ADDR_W-DATA_W){1'b0}}, dmem_dout};
  end

  // Ack in the last permitted cycle wins over the abort.
  assign timeout_hit = TO_EN && !dmem_ack && (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = req_mode[1] ? S_IND : S_ACC;
        end
      end
      S_IND: begin
        if (dmem_ack) begin
          state_d = S_PTR;
        end else if (timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_PTR: begin
        state_d = S_ACC;
      end
      S_ACC: begin
        if (dmem_ack || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-state logic (all outputs except req_ready are
  // registered from these values)
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_d        = wr_q;
    wdata_d     = wdata_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    dmem_req_d  = dmem_req_q;
    dmem_rd_d   = dmem_rd_q;
    dmem_addr_d = dmem_addr_q;
    dmem_din_d  = dmem_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    mem_out_d   = mem_out_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d        = req_mode[0];
          wdata_d     = req_wdata;
          cnt_d       = '0;
          dmem_req_d  = 1'b1;
          dmem_addr_d = req_addr;
          rsp_err_d   = 1'b0;
          // Only a direct write starts with a store; indirect modes first
          // fetch the pointer.
          dmem_rd_d   = (req_mode != 2'b01);
          if (req_mode == 2'b01) begin
            dmem_din_d = req_wdata;
          end
        end
      end
      S_IND: begin
        if (dmem_ack) begin
          ptr_d      = ptr_w;
          dmem_req_d = 1'b0;
        end else if (timeout_hit) begin
          // Abort: the second phase is never issued.
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PTR: begin
        cnt_d       = '0;
        dmem_req_d  = 1'b1;
        dmem_addr_d = ptr_q;
        dmem_rd_d   = !wr_q;
        if (wr_q) begin
          dmem_din_d = wdata_q;
        end
      end
      S_ACC: begin
        if (dmem_ack) begin
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (dmem_rd_q) begin
            mem_out_d = dmem_dout;
          end
        end else if (timeout_hit) begin
          dmem_req_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        dmem_req_d  = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      dmem_req_q  <= 1'b0;
      dmem_rd_q   <= 1'b0;
      dmem_addr_q <= '0;
      dmem_din_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      mem_out_q   <= '0;
    end else begin
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dmem_req_q  <= dmem_req_d;
      dmem_rd_q   <= dmem_rd_d;
      dmem_addr_q <= dmem_addr_d;
      dmem_din_q  <= dmem_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      mem_out_q   <= mem_out_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign dmem_req  = dmem_req_q;
  assign dmem_rd   = dmem_rd_q;
  assign dmem_addr = dmem_addr_q;
  assign dmem_din  = dmem_din_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign mem_out   = mem_out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memaccess_hs_unit.sv
// -----------------------------------------------------------------------------
// tb_memaccess_hs_unit
//
// Bench for memaccess_hs_unit (TIMEOUT=4). A memory responder plays the data
// memory and checks every request phase against descriptors produced by a
// word-level reference model; a response monitor pops expected responses
// (error flag, read result, arrival cycle) from exp_q.
// -----------------------------------------------------------------------------
module tb_memaccess_hs_unit;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TO = 4;
  localparam int EW = 1 + DW + 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_mode;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          dmem_req;
  logic          dmem_rd;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_din;
  logic          dmem_ack = 1'b0;
  logic [DW-1:0] dmem_dout = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] mem_out;
  logic          rsp_err;
  logic [2:0]    dbg_state;

  memaccess_hs_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO),
    .CNT_W  (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_mode (req_mode),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .dmem_req (dmem_req),
    .dmem_rd  (dmem_rd),
    .dmem_addr(dmem_addr),
    .dmem_din (dmem_din),
    .dmem_ack (dmem_ack),
    .dmem_dout(dmem_dout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .mem_out  (mem_out),
    .rsp_err  (rsp_err),
    .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] data;     // word the memory returns on ack
    logic          chk_din;
    logic          tmo;      // phase is expected to time out
    logic          gap;      // phase must follow exactly one idle cycle
    int            lat;      // ack in request cycle lat (0-based)
  } phase_t;

  phase_t        phase_q[$];
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mem_m [logic [AW-1:0]];
  logic [DW-1:0] exp_mo = '0;
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            force_low = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 16'h5A5A;
  endfunction

  function automatic int pick_lat();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(4, 6));
    return int'($urandom_range(0, 3));
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: present a request, and at the accepting edge push the model's
  // expectations (memory phases and the response).
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [1:0] m, input logic [AW-1:0] a,
                       input logic [DW-1:0] w, input int l1, input int l2);
    phase_t        p;
    int            n;
    int            guard;
    int            rc;
    logic          t1;
    logic          t2;
    logic          err;
    logic [AW-1:0] ptr;
    req_valid = 1'b1;
    req_mode  = m;
    req_addr  = a;
    req_wdata = w;
    guard = 0;
    @(negedge clock);
    while (!req_ready && guard < 300) begin
      guard++;
      @(negedge clock);
    end
    if (!req_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept: req_ready stayed 0 for %0d cycles", guard);
      req_valid = 1'b0;
      return;
    end
    n   = cyc;
    t1  = (l1 >= TO);
    err = t1;
    p.rd = (m != 2'b01); p.addr = a; p.din = w; p.data = mem_rd(a);
    p.chk_din = (m == 2'b01); p.tmo = t1; p.gap = 1'b0; p.lat = l1;
    phase_q.push_back(p);
    if (!m[1]) begin
      if (!t1) begin
        if (m[0]) mem_m[a] = w;
        else exp_mo = mem_rd(a);
      end
      rc = n + 2 + (t1 ? TO - 1 : l1);
    end else if (t1) begin
      rc = n + 1 + TO;
    end else begin
      ptr = mem_rd(a);
      t2  = (l2 >= TO);
      err = t2;
      p.rd = !m[0]; p.addr = ptr; p.din = w; p.data = mem_rd(ptr);
      p.chk_din = m[0]; p.tmo = t2; p.gap = 1'b1; p.lat = l2;
      phase_q.push_back(p);
      if (!t2) begin
        if (m[0]) mem_m[ptr] = w;
        else exp_mo = mem_rd(ptr);
      end
      rc = n + 3 + l1 + (t2 ? TO : l2 + 1);
    end
    exp_q.push_back({err, exp_mo, 32'(rc)});
    @(posedge clock);
    #1;
    // Junk on the request inputs while busy must be ignored.
    req_valid = 1'b0;
    req_mode  = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || phase_q.size() != 0 || !req_ready) && g < 400) begin
      g++;
      @(negedge clock);
    end
    if (g >= 400) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_wait: outstanding exp=%0d phases=%0d", exp_q.size(), phase_q.size());
    end
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Response backpressure
  // ---------------------------------------------------------------------------
  always @(posedge clock) begin
    #1;
    rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------------------------------------------------------------------
  // Memory responder: checks each request phase, returns data after lat cycles
  // ---------------------------------------------------------------------------
  phase_t cur;
  bit     in_ph    = 1'b0;
  bit     ph_acked = 1'b0;
  int     rq_cyc   = 0;
  int     low_cnt  = 0;

  task automatic drive_ack();
    if (rq_cyc - 1 == cur.lat) begin
      dmem_ack  = 1'b1;
      dmem_dout = cur.data;
      ph_acked  = 1'b1;
    end else begin
      dmem_ack  = 1'b0;
      dmem_dout = 16'($urandom);
    end
  endtask

  task automatic chk_phase_sig();
    chk("dmem_rd", 32'(dmem_rd), 32'(cur.rd));
    chk("dmem_addr", 32'(dmem_addr), 32'(cur.addr));
    if (cur.chk_din) chk("dmem_din", 32'(dmem_din), 32'(cur.din));
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      in_ph    = 1'b0;
      ph_acked = 1'b0;
      low_cnt  = 0;
      dmem_ack = 1'b0;
    end else begin
      if (in_ph && (!dmem_req || ph_acked)) begin
        if (ph_acked) begin
          chk("req_drop_after_ack", 32'(dmem_req), 32'd0);
          chk("phase_no_timeout", 32'(cur.tmo), 32'd0);
        end else begin
          chk("phase_timeout", 32'(cur.tmo), 32'd1);
          chk("timeout_len", 32'(rq_cyc), 32'(TO));
        end
        in_ph   = 1'b0;
        low_cnt = 0;
      end
      if (in_ph) begin
        rq_cyc++;
        chk_phase_sig();
        drive_ack();
      end else if (dmem_req) begin
        if (phase_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_dmem_req: addr %0h", dmem_addr);
          dmem_ack = 1'b0;
        end else begin
          cur      = phase_q.pop_front();
          in_ph    = 1'b1;
          ph_acked = 1'b0;
          rq_cyc   = 1;
          if (cur.gap) chk("ptr_gap", 32'(low_cnt), 32'd1);
          chk_phase_sig();
          drive_ack();
        end
      end else begin
        // Acks while dmem_req=0 must be ignored by the DUT.
        low_cnt++;
        dmem_ack  = 1'($urandom_range(0, 1));
        dmem_dout = 16'($urandom);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response monitor
  // ---------------------------------------------------------------------------
  bit            have    = 1'b0;
  bit            hs_prev = 1'b0;
  logic          err_h;
  logic [DW-1:0] mo_h;
  logic [EW-1:0] e;

  always @(negedge clock) begin
    if (!reset) begin
      have    = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        chk("req_ready_after_hs", 32'(req_ready), 32'd1);
      end
      hs_prev = 1'b0;
      if (rsp_valid) begin
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (!have) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: mem_out %0h err %0b", mem_out, rsp_err);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_err", 32'(rsp_err), 32'(e[EW-1]));
            chk("mem_out", 32'(mem_out), 32'(e[EW-2:32]));
            chk("rsp_cycle", 32'(cyc), e[31:0]);
          end
          have  = 1'b1;
          err_h = rsp_err;
          mo_h  = mem_out;
        end else begin
          chk("rsp_err_hold", 32'(rsp_err), 32'(err_h));
          chk("mem_out_hold", 32'(mem_out), 32'(mo_h));
        end
        if (rsp_ready) begin
          have    = 1'b0;
          hs_prev = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus and final report
  // ---------------------------------------------------------------------------
  initial begin
    req_valid = 1'b0;
    req_mode  = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    mem_m[16'h3000] = 16'hBEEF;
    mem_m[16'h4000] = 16'h4100;
    mem_m[16'h4100] = 16'hCAFE;
    mem_m[16'h4800] = 16'h5000;

    // Reset values
    #1;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_rd", 32'(dmem_rd), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_dmem_din", 32'(dmem_din), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_out", 32'(mem_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    #21;
    reset = 1'b1;
    @(negedge clock);
    chk("req_ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;

    // Direct read, ack 2 cycles in
    issue(2'b00, 16'h3000, 16'h0000, 2, 0);
    wait_idle();
    // Direct write, zero-wait ack
    issue(2'b01, 16'h3005, 16'h1234, 0, 0);
    wait_idle();
    // Indirect read through 0x4000 -> 0x4100
    issue(2'b10, 16'h4000, 16'h0000, 1, 1);
    wait_idle();

    // Indirect write with rsp_ready held low
    force_low = 1'b1;
    issue(2'b11, 16'h4800, 16'h00FF, 0, 2);
    begin
      int g;
      g = 0;
      while (!rsp_valid && g < 50) begin
        g++;
        @(negedge clock);
      end
      if (!rsp_valid) begin
        n_tests++;
        n_fail++;
        $display("FAIL bp_rsp_wait: rsp_valid never rose");
      end
    end
    repeat (5) begin
      @(negedge clock);
      chk("bp_rsp_hold", 32'(rsp_valid), 32'd1);
    end
    force_low = 1'b0;
    wait_idle();

    // Timeouts: never acked, ack in the last permitted cycle, one past it
    issue(2'b00, 16'h3000, 16'h0000, 50, 0);
    wait_idle();
    issue(2'b00, 16'h3000, 16'h0000, TO - 1, 0);
    wait_idle();
    issue(2'b00, 16'h3005, 16'h0000, TO, 0);
    wait_idle();
    issue(2'b10, 16'h4000, 16'h0000, TO + 2, 0);
    wait_idle();
    issue(2'b11, 16'h4800, 16'h7777, 1, TO);
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [1:0]    m;
      logic [AW-1:0] a;
      m = 2'($urandom_range(0, 3));
      a = 16'h6000 + 16'($urandom_range(0, 7));
      issue(m, a, 16'($urandom), pick_lat(), pick_lat());
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    // Reset during the pointer fetch
    issue(2'b10, 16'h4000, 16'h0000, 3, 0);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_dmem_req", 32'(dmem_req), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    phase_q.delete();
    exp_mo = '0;
    @(negedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    #1;
    issue(2'b00, 16'h3000, 16'h0000, 1, 0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memaccess_hs_unit.md
Name: memaccess_hs_unit

Overview:
- Parametrised, handshaked successor to the LC3 MemAccess stage. It drives dmem_addr, dmem_din and dmem_rd, and returns mem_out.
- Accepts one access request at a time from the execute/controller side and supports direct read, direct write, indirect read (LDI) and indirect write (STI).
- Talks to a data memory with variable latency through a req/ack handshake.
- Returns completion with an optional timeout error through a valid/ready response port.

Parameters:
- DATA_W, 16: data word width.
- ADDR_W, 16: address width. The indirect pointer is dmem_dout zero-extended or truncated to ADDR_W.
- TIMEOUT, 0: maximum cycles to wait for dmem_ack in one phase. 0 disables the timeout.
- CNT_W, 8: timeout counter width. Requires TIMEOUT < 2**CNT_W.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_mode  input  2  access mode: 00 read, 01 write, 10 indirect read, 11 indirect write.
- req_addr  input  ADDR_W  effective or pointer address.
- req_wdata  input  DATA_W  store data.
- dmem_req  output  1  memory request strobe.
- dmem_rd  output  1  1 = read, 0 = write.
- dmem_addr  output  ADDR_W  memory address.
- dmem_din  output  DATA_W  memory write data.
- dmem_ack  input  1  memory completion; sampled only while dmem_req=1.
- dmem_dout  input  DATA_W  memory read data; valid with dmem_ack.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- mem_out  output  DATA_W  read result.
- rsp_err  output  1  response carries a timeout abort.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - dmem_req, dmem_rd, rsp_valid and rsp_err are 0.
  - dmem_addr, dmem_din and mem_out are 0.
  - Timeout counter is 0.
  - req_ready is 1 once reset is released.
- Reset asserted mid-operation: the transaction is discarded immediately and dmem_req drops asynchronously.
- States: IDLE, IND, PTR, ACC, RESP. All outputs except req_ready are registered. req_ready = (state==IDLE).
- IDLE:
  - On req_valid&&req_ready, latch mode, addr and wdata.
  - Mode 10 or 11: go to IND with dmem_req=1, dmem_rd=1, dmem_addr=req_addr.
  - Mode 00: go to ACC with dmem_rd=1.
  - Mode 01: go to ACC with dmem_rd=0 and dmem_din=req_wdata.
  - dmem_req=1 from the next cycle. rsp_err is cleared on acceptance.
- IND:
  - On dmem_ack, latch the pointer from dmem_dout, drop dmem_req and go to PTR.
- PTR:
  - Exactly one cycle with dmem_req=0.
  - Then go to ACC with dmem_addr=pointer.
  - Mode 10: dmem_rd=1. Mode 11: dmem_rd=0 and dmem_din=wdata.
  - dmem_req=1.
- ACC:
  - On dmem_ack, drop dmem_req. For a read, also set mem_out=dmem_dout.
  - Go to RESP with rsp_valid=1 and rsp_err=0.
  - Writes leave mem_out unchanged.
- RESP:
  - Hold rsp_valid, mem_out and rsp_err stable until rsp_ready.
  - Then go to IDLE with rsp_valid=0.
  - No new request is accepted in the same cycle; req_ready rises the cycle after the response handshake.
- Timeout, when TIMEOUT>0:
  - The counter clears on entry to IND or ACC and increments each cycle in those states while dmem_ack=0.
  - When the count reaches TIMEOUT without ack: dmem_req=0, go to RESP with rsp_err=1, mem_out unchanged. An indirect access does not perform its second phase.
  - dmem_ack in the same cycle the count reaches TIMEOUT counts as success.
- dmem_addr, dmem_rd and dmem_din are stable for as long as dmem_req=1.
- dmem_ack while dmem_req=0 is ignored.
- Latency from accept cycle N, with ack in the first request cycle:
  - Direct access: dmem_req high at N+1, rsp_valid at N+2.
  - Indirect access: IND at N+1, PTR at N+2, ACC at N+3, rsp_valid at N+4.
- Illegal input changes are ignored: inputs other than rsp_ready and dmem_* are not sampled outside IDLE.

Test Plan:
- Direct read: mode 00, addr 0x3000; memory acks 2 cycles after dmem_req with 0xBEEF → dmem_rd=1, dmem_addr=0x3000 stable; rsp_valid with mem_out=0xBEEF, rsp_err=0.
- Direct write with zero-wait ack: mode 01, addr 0x3005, wdata 0x1234 → dmem_rd=0, dmem_din=0x1234; rsp_valid 2 cycles after accept; mem_out keeps its previous value.
- Indirect read: mode 10, addr 0x4000; memory returns 0x4100 at 0x4000 and 0xCAFE at 0x4100 → phase 1 addr 0x4000; dmem_req=0 for exactly one cycle; phase 2 addr 0x4100; mem_out=0xCAFE.
- Indirect write with backpressure: mode 11, pointer 0x5000, wdata 0x00FF; rsp_ready held low 5 cycles → write at 0x5000 with din 0x00FF; rsp_valid held 5+ cycles; req_ready=0 until the cycle after the rsp handshake.
- Timeout: TIMEOUT=4, mode 00, memory never acks → dmem_req drops after 4 cycles, rsp_err=1, mem_out unchanged. With ack arriving exactly at count 4 → success, rsp_err=0.
- Reset mid-operation: reset asserted during IND → dmem_req and rsp_valid go to 0 asynchronously, req_ready=1 after release, and the next read completes normally.
